// File: rtl/plic_claim_ctrl_if.sv
// Claim/complete bus between the PLIC target logic and plic_claim_ctrl.
// The master side is the priority tree plus the target register file;
// the slave side is plic_claim_ctrl itself.

`ifndef PLIC_PRIO_WIDTH
`define PLIC_PRIO_WIDTH 3
`endif
`ifndef PLIC_IRQ_WIDTH
`define PLIC_IRQ_WIDTH 6
`endif

interface plic_claim_ctrl_if;
   logic [`PLIC_PRIO_WIDTH-1:0] prio_i;
   logic [`PLIC_IRQ_WIDTH-1:0]  id_i;
   logic [`PLIC_PRIO_WIDTH-1:0] th_i;
   logic                        claim_i;
   logic                        complete_i;
   logic [`PLIC_IRQ_WIDTH-1:0]  complete_id_i;
   logic                        irq_o;
   logic [`PLIC_IRQ_WIDTH-1:0]  claim_id_o;
   logic                        gw_claim_o;
   logic                        gw_cpl_o;
   logic [`PLIC_IRQ_WIDTH-1:0]  gw_id_o;
   logic                        busy_o;
   logic                        cpl_err_o;
   logic                        tmo_o;

   modport master (
      output prio_i, id_i, th_i, claim_i, complete_i, complete_id_i,
      input  irq_o, claim_id_o, gw_claim_o, gw_cpl_o, gw_id_o, busy_o,
             cpl_err_o, tmo_o
   );

   modport slave (
      input  prio_i, id_i, th_i, claim_i, complete_i, complete_id_i,
      output irq_o, claim_id_o, gw_claim_o, gw_cpl_o, gw_id_o, busy_o,
             cpl_err_o, tmo_o
   );
endinterface

// File: rtl/plic_claim_ctrl.sv
// PLIC per-target claim/complete controller.
// Tracks a single outstanding claim, raises irq_o to the hart when the
// best pending source beats the threshold, and pulses the gateway on
// claim and on completion.
// Optional feature: define PLIC_CLAIM_TMO_EN to release a claim that is
// never completed after TMO_CYCLES cycles in CLAIMED.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no outstanding claim, irq_o may assert
//   CLAIMED | hart holds claimed_q, waiting for its complete

`ifndef PLIC_PRIO_WIDTH
`define PLIC_PRIO_WIDTH 3
`endif
`ifndef PLIC_IRQ_WIDTH
`define PLIC_IRQ_WIDTH 6
`endif

module plic_claim_ctrl #(
   parameter int unsigned TMO_CYCLES = 1024
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   plic_claim_ctrl_if.slave   bus
);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_CLAIMED = 1'b1;

   logic [0:0]                  state_q;
   logic [0:0]                  state_d;
   logic [`PLIC_PRIO_WIDTH-1:0] prio_q;
   logic [`PLIC_IRQ_WIDTH-1:0]  id_q;
   logic [`PLIC_IRQ_WIDTH-1:0]  claimed_q;

   logic eligible;
   logic cpl_match;
   logic take_claim;
   logic do_cpl;
   logic err_d;
   logic tmo_d;

   assign eligible  = (prio_q > bus.th_i) && (id_q != '0);
   assign cpl_match = bus.complete_i && (bus.complete_id_i == claimed_q);

`ifdef PLIC_CLAIM_TMO_EN
   localparam int unsigned     CNT_W    = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt_q;
   logic             tmo_q;
   logic             tmo_hit;

   assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
   assign bus.tmo_o = tmo_q;

   // Age of the outstanding claim; restarts on every new claim.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         if (take_claim)
            tmo_cnt_q <= '0;
         else if (state_q == ST_CLAIMED)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`else
   logic unused_tmo;
   logic tmo_hit;

   // TMO_CYCLES is only meaningful with the timeout built in.
   assign unused_tmo = ^TMO_CYCLES;
   assign tmo_hit    = 1'b0;
   assign bus.tmo_o  = 1'b0;
`endif

   // Next-state and pulse decisions from the registered request.
   always_comb begin
      state_d    = state_q;
      take_claim = 1'b0;
      do_cpl     = 1'b0;
      err_d      = 1'b0;
      tmo_d      = 1'b0;
      if (state_q == ST_IDLE) begin
         if (bus.claim_i && eligible) begin
            take_claim = 1'b1;
            state_d    = ST_CLAIMED;
         end
         if (bus.complete_i)
            err_d = 1'b1;
      end else begin
         if (cpl_match) begin
            do_cpl  = 1'b1;
            state_d = ST_IDLE;
         end else begin
            if (bus.complete_i)
               err_d = 1'b1;
            // A valid complete on the terminal cycle wins over the timeout.
            if (tmo_hit) begin
               do_cpl  = 1'b1;
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
      end
   end

   // Input pipeline, FSM state and all registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q        <= ST_IDLE;
         prio_q         <= '0;
         id_q           <= '0;
         claimed_q      <= '0;
         bus.claim_id_o <= '0;
         bus.gw_id_o    <= '0;
         bus.irq_o      <= 1'b0;
         bus.gw_claim_o <= 1'b0;
         bus.gw_cpl_o   <= 1'b0;
         bus.busy_o     <= 1'b0;
         bus.cpl_err_o  <= 1'b0;
      end else begin
         state_q        <= state_d;
         prio_q         <= bus.prio_i;
         id_q           <= bus.id_i;
         bus.irq_o      <= eligible && (state_d == ST_IDLE);
         bus.busy_o     <= (state_d == ST_CLAIMED);
         bus.gw_claim_o <= take_claim;
         bus.gw_cpl_o   <= do_cpl;
         bus.cpl_err_o  <= err_d;
         // Claim read data is sticky; a refused claim reads back zero.
         if (bus.claim_i)
            bus.claim_id_o <= take_claim ? id_q : '0;
         if (take_claim) begin
            claimed_q   <= id_q;
            bus.gw_id_o <= id_q;
         end else if (do_cpl) begin
            bus.gw_id_o <= claimed_q;
         end
      end
   end

endmodule

// File: tb/tb_plic_claim_ctrl.sv
`ifndef PLIC_PRIO_WIDTH
`define PLIC_PRIO_WIDTH 3
`endif
`ifndef PLIC_IRQ_WIDTH
`define PLIC_IRQ_WIDTH 6
`endif

module tb_plic_claim_ctrl;
   localparam int PW  = `PLIC_PRIO_WIDTH;
   localparam int IW  = `PLIC_IRQ_WIDTH;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   plic_claim_ctrl_if bus ();
   plic_claim_ctrl #(.TMO_CYCLES(TMO)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   // held request inputs
   logic [PW-1:0] cur_prio = '0;
   logic [IW-1:0] cur_id   = '0;
   logic [PW-1:0] cur_th   = '0;

   // behavioural model: one hart, at most one outstanding claim
   int unsigned   m_prio_q, m_id_q;
   bit            m_claimed;
   int unsigned   m_cid, m_claim_id, m_gw_id, m_age;
   bit            e_irq, e_busy, e_gw_claim, e_gw_cpl, e_err, e_tmo;

   function automatic void model_reset();
      m_prio_q = 0; m_id_q = 0; m_claimed = 0; m_cid = 0;
      m_claim_id = 0; m_gw_id = 0; m_age = 0;
      e_irq = 0; e_busy = 0; e_gw_claim = 0; e_gw_cpl = 0; e_err = 0; e_tmo = 0;
   endfunction

   function automatic void model_step(input int unsigned th, input bit claim,
                                      input bit cpl, input int unsigned cpl_id,
                                      input int unsigned prio, input int unsigned id);
      bit elig;
      elig = (m_prio_q > th) && (m_id_q != 0);
      e_gw_claim = 0; e_gw_cpl = 0; e_err = 0; e_tmo = 0;
      if (!m_claimed) begin
         if (claim) begin
            if (elig) begin
               m_claim_id = m_id_q; m_cid = m_id_q; m_gw_id = m_id_q;
               e_gw_claim = 1; m_claimed = 1; m_age = 0;
            end else begin
               m_claim_id = 0;
            end
         end
         if (cpl) e_err = 1;
      end else begin
         m_age++;
         if (claim) m_claim_id = 0;
         if (cpl && cpl_id == m_cid) begin
            e_gw_cpl = 1; m_gw_id = m_cid; m_claimed = 0;
         end else begin
            if (cpl) e_err = 1;
`ifdef PLIC_CLAIM_TMO_EN
            if (m_age == TMO) begin
               e_gw_cpl = 1; e_tmo = 1; m_gw_id = m_cid; m_claimed = 0;
            end
`endif
         end
      end
      e_irq  = elig && !m_claimed;
      e_busy = m_claimed;
      m_prio_q = prio;
      m_id_q   = id;
   endfunction

   // one clock with the given pulses; outputs are settled on return
   task automatic cyc(input bit claim, input bit cpl, input logic [IW-1:0] cpl_id);
      bus.prio_i        = cur_prio;
      bus.id_i          = cur_id;
      bus.th_i          = cur_th;
      bus.claim_i       = claim;
      bus.complete_i    = cpl;
      bus.complete_id_i = cpl_id;
      model_step(cur_th, claim, cpl, cpl_id, cur_prio, cur_id);
      @(posedge clk);
      #1;
      bus.claim_i    = 1'b0;
      bus.complete_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      cur_prio = '0; cur_id = '0; cur_th = '0;
      bus.prio_i = '0; bus.id_i = '0; bus.th_i = '0;
      bus.claim_i = 1'b0; bus.complete_i = 1'b0; bus.complete_id_i = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({bus.irq_o, bus.busy_o, bus.gw_claim_o, bus.gw_cpl_o, bus.cpl_err_o, bus.tmo_o,
           bus.claim_id_o, bus.gw_id_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: irq=%b busy=%b gwc=%b gwp=%b err=%b tmo=%b cid=%0d gid=%0d, want all 0",
                  bus.irq_o, bus.busy_o, bus.gw_claim_o, bus.gw_cpl_o, bus.cpl_err_o, bus.tmo_o,
                  bus.claim_id_o, bus.gw_id_o);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_claim_basic();
      cur_prio = 3; cur_id = 5; cur_th = 1;
      idle(1);
      n_tests++;
      if (bus.irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_latency1: got %b want 0", bus.irq_o); end
      idle(1);
      n_tests++;
      if (bus.irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_before_claim: got %b want 1", bus.irq_o); end
      cyc(1'b1, 1'b0, '0);
      n_tests++;
      if (bus.claim_id_o !== 5 || bus.gw_claim_o !== 1'b1 || bus.gw_id_o !== 5 ||
          bus.irq_o !== 1'b0 || bus.busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL claim_5: cid=%0d gwc=%b gid=%0d irq=%b busy=%b want 5 1 5 0 1",
                  bus.claim_id_o, bus.gw_claim_o, bus.gw_id_o, bus.irq_o, bus.busy_o);
      end
      idle(1);
      n_tests++;
      if (bus.gw_claim_o !== 1'b0 || bus.claim_id_o !== 5) begin
         n_fail++;
         $display("FAIL claim_pulse_hold: gwc=%b cid=%0d want 0 5", bus.gw_claim_o, bus.claim_id_o);
      end
   endtask

   task automatic test_complete();
      cyc(1'b0, 1'b1, IW'(4));
      n_tests++;
      if (bus.cpl_err_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.gw_cpl_o !== 1'b0) begin
         n_fail++;
         $display("FAIL cpl_wrong_id: err=%b busy=%b gwp=%b want 1 1 0", bus.cpl_err_o, bus.busy_o, bus.gw_cpl_o);
      end
      cyc(1'b0, 1'b1, IW'(5));
      n_tests++;
      if (bus.gw_cpl_o !== 1'b1 || bus.gw_id_o !== 5 || bus.busy_o !== 1'b0 || bus.cpl_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL cpl_ok: gwp=%b gid=%0d busy=%b err=%b want 1 5 0 0",
                  bus.gw_cpl_o, bus.gw_id_o, bus.busy_o, bus.cpl_err_o);
      end
      cyc(1'b0, 1'b1, IW'(5));
      n_tests++;
      if (bus.cpl_err_o !== 1'b1 || bus.gw_cpl_o !== 1'b0) begin
         n_fail++;
         $display("FAIL cpl_in_idle: err=%b gwp=%b want 1 0", bus.cpl_err_o, bus.gw_cpl_o);
      end
   endtask

   task automatic test_threshold();
      cur_prio = 2; cur_id = 5; cur_th = 2;
      idle(2);
      n_tests++;
      if (bus.irq_o !== 1'b0) begin n_fail++; $display("FAIL th_equal_irq: got %b want 0", bus.irq_o); end
      cyc(1'b1, 1'b0, '0);
      n_tests++;
      if (bus.claim_id_o !== 0 || bus.gw_claim_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL th_equal_claim: cid=%0d gwc=%b busy=%b want 0 0 0",
                  bus.claim_id_o, bus.gw_claim_o, bus.busy_o);
      end
   endtask

   task automatic test_back_to_back();
      cur_prio = 3; cur_id = 5; cur_th = 1;
      idle(2);
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, IW'(5));
      n_tests++;
      if (bus.claim_id_o !== 0 || bus.gw_cpl_o !== 1'b1 || bus.gw_id_o !== 5 ||
          bus.busy_o !== 1'b0 || bus.gw_claim_o !== 1'b0) begin
         n_fail++;
         $display("FAIL claim_and_cpl: cid=%0d gwp=%b gid=%0d busy=%b gwc=%b want 0 1 5 0 0",
                  bus.claim_id_o, bus.gw_cpl_o, bus.gw_id_o, bus.busy_o, bus.gw_claim_o);
      end
   endtask

   task automatic test_timeout();
      int busy_cnt;
      bit seen_tmo;
      bit lost_busy;
      cur_prio = 4; cur_id = 7; cur_th = 0;
      idle(2);
      cyc(1'b1, 1'b0, '0);
`ifdef PLIC_CLAIM_TMO_EN
      busy_cnt = 0; seen_tmo = 0;
      for (int i = 0; i < 20 && !seen_tmo; i++) begin
         if (bus.busy_o === 1'b1) busy_cnt++;
         if (bus.tmo_o === 1'b1) seen_tmo = 1;
         else idle(1);
      end
      n_tests++;
      if (!seen_tmo || busy_cnt != TMO || bus.gw_cpl_o !== 1'b1 || bus.gw_id_o !== 7 || bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout: seen=%0d busy_cycles=%0d gwp=%b gid=%0d busy=%b want 1 %0d 1 7 0",
                  seen_tmo, busy_cnt, bus.gw_cpl_o, bus.gw_id_o, bus.busy_o, TMO);
      end
      idle(1);
      n_tests++;
      if (bus.tmo_o !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: tmo=%b want 0", bus.tmo_o); end
`else
      busy_cnt = 0; lost_busy = 0; seen_tmo = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.busy_o !== 1'b1) lost_busy = 1;
         if (bus.tmo_o !== 1'b0) seen_tmo = 1;
         idle(1);
      end
      n_tests++;
      if (lost_busy || seen_tmo) begin
         n_fail++;
         $display("FAIL no_timeout: lost_busy=%0d tmo_seen=%0d want 0 0", lost_busy, seen_tmo);
      end
      cyc(1'b0, 1'b1, IW'(7));
`endif
   endtask

   task automatic test_reset_mid_claim();
      bit saw_cpl;
      cur_prio = 3; cur_id = 9; cur_th = 1;
      idle(2);
      cyc(1'b1, 1'b0, '0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({bus.irq_o, bus.busy_o, bus.gw_claim_o, bus.gw_cpl_o, bus.cpl_err_o, bus.tmo_o,
           bus.claim_id_o, bus.gw_id_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_async: irq=%b busy=%b gwc=%b cid=%0d gid=%0d want all 0",
                  bus.irq_o, bus.busy_o, bus.gw_claim_o, bus.claim_id_o, bus.gw_id_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      saw_cpl = 0;
      idle(1);
      if (bus.gw_cpl_o !== 1'b0) saw_cpl = 1;
      n_tests++;
      if (bus.irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq_1: irq=%b want 0", bus.irq_o); end
      idle(1);
      if (bus.gw_cpl_o !== 1'b0) saw_cpl = 1;
      n_tests++;
      if (bus.irq_o !== 1'b1 || saw_cpl) begin
         n_fail++;
         $display("FAIL reset_irq_2: irq=%b gw_cpl_seen=%0d want 1 0", bus.irq_o, saw_cpl);
      end
   endtask

   task automatic test_random();
      logic [IW-1:0] cid;
      bit claim, cpl;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         cur_prio = PW'($urandom);
         cur_id   = ($urandom_range(0, 5) == 0) ? '0 : IW'($urandom);
         cur_th   = PW'($urandom_range(0, 3));
         claim    = ($urandom_range(0, 3) == 0);
         cpl      = ($urandom_range(0, 4) == 0);
         cid      = ($urandom_range(0, 1) == 0) ? IW'(m_cid) : IW'($urandom);
         cyc(claim, cpl, cid);
         n_tests++;
         if (bus.irq_o !== e_irq || bus.busy_o !== e_busy || bus.gw_claim_o !== e_gw_claim ||
             bus.gw_cpl_o !== e_gw_cpl || bus.cpl_err_o !== e_err || bus.tmo_o !== e_tmo ||
             bus.claim_id_o !== IW'(m_claim_id) || bus.gw_id_o !== IW'(m_gw_id)) begin
            n_fail++;
            $display("FAIL random[%0d]: irq/busy/gwc/gwp/err/tmo=%b%b%b%b%b%b cid=%0d gid=%0d want %b%b%b%b%b%b cid=%0d gid=%0d",
                     i, bus.irq_o, bus.busy_o, bus.gw_claim_o, bus.gw_cpl_o, bus.cpl_err_o, bus.tmo_o,
                     bus.claim_id_o, bus.gw_id_o, e_irq, e_busy, e_gw_claim, e_gw_cpl, e_err, e_tmo,
                     m_claim_id, m_gw_id);
         end
      end
   endtask

   initial begin
      test_reset();
      test_claim_basic();
      test_complete();
      test_threshold();
      test_back_to_back();
      test_timeout();
      test_reset_mid_claim();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
